// File: rtl/ifetch_bus_pkg.sv
// ============================================================================
// Module   : ifetch_bus_pkg
// Desc     : Shared types and defaults for the instruction-fetch stage:
//            fetch FSM state encoding, reset PC, instruction size, AXI resp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_bus_pkg;

    // Fetch FSM: IDLE -> REQ -> WAIT_R -> HOLD -> REQ ...
    typedef enum logic [1:0] {
        IFU_IDLE   = 2'd0,
        IFU_REQ    = 2'd1,
        IFU_WAIT_R = 2'd2,
        IFU_HOLD   = 2'd3
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
    localparam int unsigned IFU_INST_BYTES = 4;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

endpackage

`default_nettype wire

// File: rtl/ifetch_bus_if.sv
// ============================================================================
// Module   : ifetch_bus_if
// Desc     : AXI4-Lite read-only bundle (AR + R channels) between the fetch
//            stage (master) and instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifetch_bus_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

`default_nettype wire

// File: rtl/ifetch_bus_ifu_axi_rd.sv
// ============================================================================
// Module   : ifu_axi_rd
// Desc     : Fetch sequencing FSM. Drives the AR/R channels (one read in
//            flight), keeps the registered read address and the discard flag
//            that marks an in-flight read whose data must be thrown away
//            because a redirect arrived after it was issued.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_axi_rd
    import ifetch_bus_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ifetch_bus_if.master     axi,
    input  wire logic        redirect_valid,
    input  wire logic [31:0] load_addr,     // address for the next request
    input  wire logic        release_hold,  // decode took the held instruction
    output ifu_state_e       state,
    output logic             capture        // accept rdata into the F outputs
);

    ifu_state_e  r_state;
    ifu_state_e  w_state_next;
    logic [31:0] r_araddr;
    logic [31:0] w_araddr_next;
    logic        r_discard;
    logic        w_discard_next;

    // State, request address and discard flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IFU_IDLE;
            r_araddr  <= RESET_PC;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_araddr  <= w_araddr_next;
            r_discard <= w_discard_next;
        end
    end

    // Next-state logic; araddr only moves when no request is being offered
    always_comb begin
        w_state_next   = r_state;
        w_araddr_next  = r_araddr;
        w_discard_next = r_discard;
        capture        = 1'b0;
        case (r_state)
            IFU_IDLE: begin
                w_araddr_next = load_addr;
                w_state_next  = IFU_REQ;
            end
            IFU_REQ: begin
                // Request must complete untouched; its data is dropped later
                if (redirect_valid) begin
                    w_discard_next = 1'b1;
                end
                if (axi.arready) begin
                    w_state_next = IFU_WAIT_R;
                end
            end
            IFU_WAIT_R: begin
                if (axi.rvalid) begin
                    if (r_discard || redirect_valid) begin
                        w_discard_next = 1'b0;
                        w_araddr_next  = load_addr;
                        w_state_next   = IFU_REQ;
                    end else begin
                        capture      = 1'b1;
                        w_state_next = IFU_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_discard_next = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (redirect_valid || release_hold) begin
                    w_araddr_next = load_addr;
                    w_state_next  = IFU_REQ;
                end
            end
            default: begin
                w_state_next = IFU_IDLE;
            end
        endcase
    end

    assign axi.araddr  = r_araddr;
    assign axi.arvalid = (r_state == IFU_REQ);
    assign axi.rready  = (r_state == IFU_WAIT_R);
    assign state       = r_state;

endmodule

`default_nettype wire

// File: rtl/ifetch_bus.sv
// ============================================================================
// Module   : ifetch_bus
// Desc     : Instruction-fetch stage. Owns the PC, issues one AXI4-Lite read
//            per instruction and presents {instF, pcF, snpcF} to decode via
//            a valid/ready handshake. Redirects override sequential flow.
// Config   : IFU_FAULT_EN - when defined, fetch_fault reports rresp != OKAY
//            for the delivered word; otherwise fetch_fault is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_bus
    import ifetch_bus_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
    parameter int unsigned INST_BYTES = IFU_INST_BYTES
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ifetch_bus_if.master     axi,
    input  wire logic        redirect_valid,
    input  wire logic [31:0] redirect_pc,
    output logic [31:0]      instF,
    output logic [31:0]      pcF,
    output logic [31:0]      snpcF,
    output logic             m_valid,
    input  wire logic        m_ready,
    output logic             fetch_fault
);

    localparam logic [31:0] INC = 32'(INST_BYTES);

    ifu_state_e  state;
    logic        capture;
    logic        w_release;
    logic [31:0] w_load_addr;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_pc_f;
    logic [31:0] r_snpc_f;

    // A redirect in HOLD kills the held instruction in the same cycle
    assign m_valid   = (state == IFU_HOLD) & ~redirect_valid;
    assign w_release = m_valid & m_ready;

    // Address for the next request: redirect target, next sequential, or PC
    always_comb begin
        w_load_addr = r_pc;
        if (redirect_valid) begin
            w_load_addr = redirect_pc;
        end else if (state == IFU_HOLD) begin
            w_load_addr = r_snpc_f;
        end
    end

    // Architectural fetch PC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_release) begin
            r_pc <= r_snpc_f;
        end
    end

    // Capture of the returned instruction toward decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst   <= 32'h0;
            r_pc_f   <= RESET_PC;
            r_snpc_f <= RESET_PC + INC;
        end else if (capture) begin
            r_inst   <= axi.rdata;
            r_pc_f   <= axi.araddr;
            r_snpc_f <= axi.araddr + INC;
        end
    end

    ifu_axi_rd #(
        .RESET_PC (RESET_PC)
    ) u_axi_rd (
        .clk            (clk),
        .rst            (rst),
        .axi            (axi),
        .redirect_valid (redirect_valid),
        .load_addr      (w_load_addr),
        .release_hold   (w_release),
        .state          (state),
        .capture        (capture)
    );

    assign instF = r_inst;
    assign pcF   = r_pc_f;
    assign snpcF = r_snpc_f;

`ifdef IFU_FAULT_EN
    logic r_fault;

    // Fault flag follows the captured word; cleared when it leaves HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (capture) begin
            r_fault <= (axi.rresp != AXI_RESP_OKAY);
        end else if ((state == IFU_HOLD) && (w_release || redirect_valid)) begin
            r_fault <= 1'b0;
        end
    end

    assign fetch_fault = r_fault;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_bus.sv
// ============================================================================
// Module   : tb_ifetch_bus
// Desc     : Self-checking bench for ifetch_bus: directed scenarios plus a
//            randomized run against a behavioural model of the fetch stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_bus;
    import ifetch_bus_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef IFU_FAULT_EN
    localparam logic FAULT_EN = 1'b1;
`else
    localparam logic FAULT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        m_ready;
    logic [31:0] instF;
    logic [31:0] pcF;
    logic [31:0] snpcF;
    logic        m_valid;
    logic        fetch_fault;
    int          checks = 0;
    int          errors = 0;

    ifetch_bus_if bus();

    ifetch_bus #(.RESET_PC(RST_PC), .INST_BYTES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .axi            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instF          (instF),
        .pcF            (pcF),
        .snpcF          (snpcF),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Addresses whose read returns SLVERR in the random run
    function automatic logic fault_of(input logic [31:0] a);
        return ((a >> 2) % 7) == 3;
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        bus.arready    = 1'b0;
        bus.rvalid     = 1'b0;
        bus.rdata      = 32'h0;
        bus.rresp      = 2'b00;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        m_ready        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance with a zero-wait memory until m_valid or the budget expires
    task automatic wait_mvalid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.rdata = mem_word(bus.araddr);
            #1;
            if (m_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_rready(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.rready === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl arvalid=%b rready=%b m_valid=%b required 0 0 0", bus.arvalid, bus.rready, m_valid);
        end
        checks++;
        if (bus.araddr !== RST_PC || pcF !== RST_PC || snpcF !== 32'h8000_0004 || instF !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs araddr=%h pcF=%h snpcF=%h instF=%h required %h %h 80000004 0", bus.araddr, pcF, snpcF, instF, RST_PC, RST_PC);
        end
        checks++;
        if (fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault got=%b required 0", fetch_fault);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle arvalid=%b required 0", bus.arvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== RST_PC) begin
            errors++;
            $display("FAIL first_req arvalid=%b araddr=%h required 1 %h", bus.arvalid, bus.araddr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int n_ar = 0;
        int n_mv = 0;
        do_reset();
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        m_ready     = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            bus.rdata = mem_word(bus.araddr);
            #1;
            if (bus.arvalid === 1'b1) begin
                checks++;
                if (bus.araddr !== RST_PC + 32'(4 * n_ar)) begin
                    errors++;
                    $display("FAIL stream_araddr got=%h required %h", bus.araddr, RST_PC + 32'(4 * n_ar));
                end
                n_ar++;
            end
            checks++;
            if (m_valid !== ((cyc % 3) == 2)) begin
                errors++;
                $display("FAIL stream_mvalid cyc=%0d got=%b required %b", cyc, m_valid, ((cyc % 3) == 2));
            end
            if (m_valid === 1'b1) begin
                checks++;
                if (pcF !== RST_PC + 32'(4 * n_mv) || snpcF !== RST_PC + 32'(4 * n_mv + 4) || instF !== mem_word(RST_PC + 32'(4 * n_mv))) begin
                    errors++;
                    $display("FAIL stream_out pcF=%h snpcF=%h instF=%h required %h %h %h", pcF, snpcF, instF,
                             RST_PC + 32'(4 * n_mv), RST_PC + 32'(4 * n_mv + 4), mem_word(RST_PC + 32'(4 * n_mv)));
                end
                n_mv++;
            end
        end
        checks++;
        if (n_mv != 3 || n_ar != 4) begin
            errors++;
            $display("FAIL stream_count deliveries=%0d requests=%0d required 3 4", n_mv, n_ar);
        end
    endtask

    task automatic test_ar_stall();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.arvalid !== 1'b1 || bus.araddr !== RST_PC) begin
                errors++;
                $display("FAIL ar_stall arvalid=%b araddr=%h required 1 %h", bus.arvalid, bus.araddr, RST_PC);
            end
        end
        @(negedge clk);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        #1;
        checks++;
        if (bus.rready !== 1'b1 || bus.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL ar_accept rready=%b arvalid=%b required 1 0", bus.rready, bus.arvalid);
        end
    endtask

    task automatic test_r_delay();
        do_reset();
        m_ready     = 1'b1;
        bus.arready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.rready !== 1'b1 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL r_wait rready=%b m_valid=%b required 1 0", bus.rready, m_valid);
            end
        end
        bus.rvalid = 1'b1;
        bus.rdata  = mem_word(RST_PC);
        @(negedge clk);
        bus.rvalid = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b1 || instF !== mem_word(RST_PC) || pcF !== RST_PC || snpcF !== RST_PC + 32'd4) begin
            errors++;
            $display("FAIL r_capture m_valid=%b instF=%h pcF=%h snpcF=%h required 1 %h %h %h", m_valid, instF, pcF, snpcF,
                     mem_word(RST_PC), RST_PC, RST_PC + 32'd4);
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        do_reset();
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        wait_mvalid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout m_valid=%b required 1", m_valid);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_valid !== 1'b1 || bus.arvalid !== 1'b0 || instF !== mem_word(RST_PC) || pcF !== RST_PC || snpcF !== RST_PC + 32'd4) begin
                errors++;
                $display("FAIL bp_hold m_valid=%b arvalid=%b instF=%h pcF=%h snpcF=%h required 1 0 %h %h %h", m_valid, bus.arvalid,
                         instF, pcF, snpcF, mem_word(RST_PC), RST_PC, RST_PC + 32'd4);
            end
            @(negedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || bus.arvalid !== 1'b1 || bus.araddr !== RST_PC + 32'd4) begin
            errors++;
            $display("FAIL bp_release m_valid=%b arvalid=%b araddr=%h required 0 1 %h", m_valid, bus.arvalid, bus.araddr, RST_PC + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        logic ok;
        do_reset();
        bus.arready = 1'b1;
        m_ready     = 1'b1;
        wait_rready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rw_timeout rready=%b required 1", bus.rready);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        @(negedge clk);
        redirect_valid = 1'b0;
        bus.rvalid     = 1'b1;
        bus.rdata      = mem_word(bus.araddr);
        #1;
        checks++;
        if (m_valid !== 1'b0 || bus.rready !== 1'b1) begin
            errors++;
            $display("FAIL rw_pending m_valid=%b rready=%b required 0 1", m_valid, bus.rready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_1000) begin
            errors++;
            $display("FAIL rw_drop m_valid=%b arvalid=%b araddr=%h required 0 1 80001000", m_valid, bus.arvalid, bus.araddr);
        end
        wait_mvalid(ok);
        checks++;
        if (!ok || pcF !== 32'h8000_1000 || instF !== mem_word(32'h8000_1000)) begin
            errors++;
            $display("FAIL rw_target m_valid=%b pcF=%h instF=%h required 1 80001000 %h", m_valid, pcF, instF, mem_word(32'h8000_1000));
        end
    endtask

    task automatic test_redirect_hold();
        logic ok;
        do_reset();
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        wait_mvalid(ok);
        m_ready        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        #1;
        checks++;
        if (!ok || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rh_kill reached=%b m_valid=%b required 1 0", ok, m_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_2000) begin
            errors++;
            $display("FAIL rh_addr arvalid=%b araddr=%h required 1 80002000", bus.arvalid, bus.araddr);
        end
        wait_mvalid(ok);
        checks++;
        if (!ok || pcF !== 32'h8000_2000 || snpcF !== 32'h8000_2004) begin
            errors++;
            $display("FAIL rh_target m_valid=%b pcF=%h snpcF=%h required 1 80002000 80002004", m_valid, pcF, snpcF);
        end
    endtask

    task automatic test_wrap();
        logic ok;
        do_reset();
        bus.arready    = 1'b1;
        bus.rvalid     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_idle_redirect arvalid=%b araddr=%h required 1 fffffffc", bus.arvalid, bus.araddr);
        end
        wait_mvalid(ok);
        checks++;
        if (!ok || pcF !== 32'hFFFF_FFFC || snpcF !== 32'h0) begin
            errors++;
            $display("FAIL wrap_snpc m_valid=%b pcF=%h snpcF=%h required 1 fffffffc 00000000", m_valid, pcF, snpcF);
        end
        m_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next arvalid=%b araddr=%h required 1 00000000", bus.arvalid, bus.araddr);
        end
    endtask

    task automatic test_fault();
        logic ok;
        do_reset();
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rresp   = 2'd2;
        wait_mvalid(ok);
        checks++;
        if (!ok || fetch_fault !== FAULT_EN || instF !== mem_word(RST_PC)) begin
            errors++;
            $display("FAIL fault_set m_valid=%b fetch_fault=%b instF=%h required 1 %b %h", m_valid, fetch_fault, instF, FAULT_EN, mem_word(RST_PC));
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || fetch_fault !== FAULT_EN) begin
            errors++;
            $display("FAIL fault_hold m_valid=%b fetch_fault=%b required 1 %b", m_valid, fetch_fault, FAULT_EN);
        end
        bus.rresp = 2'd0;
        m_ready   = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear fetch_fault=%b required 0", fetch_fault);
        end
        wait_mvalid(ok);
        checks++;
        if (!ok || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_okay m_valid=%b fetch_fault=%b required 1 0", m_valid, fetch_fault);
        end
    endtask

    // Model: delivered PCs run sequentially; a redirect sets the next one
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        logic [31:0] prev_addr;
        logic [31:0] prev_pcf;
        logic [31:0] prev_inst;
        logic        exp_fault;
        logic        pend;
        logic        prev_stall;
        logic        prev_hold;
        int          cnt;
        int          delivered;
        do_reset();
        exp_pc     = RST_PC;
        pend_addr  = 32'h0;
        prev_addr  = 32'h0;
        prev_pcf   = 32'h0;
        prev_inst  = 32'h0;
        pend       = 1'b0;
        prev_stall = 1'b0;
        prev_hold  = 1'b0;
        cnt        = 0;
        delivered  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            redirect_valid = (($urandom % 20) == 0);
            if (($urandom % 8) == 0) begin
                redirect_pc = 32'hFFFF_FFF8;
            end else begin
                redirect_pc = RST_PC + 32'($urandom_range(0, 63) * 4);
            end
            bus.arready = (($urandom % 3) != 0);
            bus.rvalid  = pend && (cnt == 0);
            bus.rdata   = pend ? mem_word(pend_addr) : 32'($urandom);
            bus.rresp   = (pend && fault_of(pend_addr)) ? 2'd2 : 2'd0;
            m_ready     = (($urandom % 2) == 0);
            #1;
            if (prev_stall) begin
                checks++;
                if (bus.arvalid !== 1'b1 || bus.araddr !== prev_addr) begin
                    errors++;
                    $display("FAIL rnd_ar_stable cyc=%0d arvalid=%b araddr=%h required 1 %h", cyc, bus.arvalid, bus.araddr, prev_addr);
                end
            end
            checks++;
            if (bus.arvalid === 1'b1 && pend) begin
                errors++;
                $display("FAIL rnd_outstanding cyc=%0d arvalid=%b with read pending required 0", cyc, bus.arvalid);
            end
            if (prev_hold) begin
                checks++;
                if (m_valid !== !redirect_valid || pcF !== prev_pcf || instF !== prev_inst) begin
                    errors++;
                    $display("FAIL rnd_hold cyc=%0d m_valid=%b pcF=%h instF=%h required %b %h %h", cyc, m_valid, pcF, instF,
                             !redirect_valid, prev_pcf, prev_inst);
                end
            end
            if (m_valid === 1'b1 && m_ready) begin
                exp_fault = FAULT_EN && fault_of(exp_pc);
                checks++;
                if (pcF !== exp_pc || snpcF !== exp_pc + 32'd4 || instF !== mem_word(exp_pc) || fetch_fault !== exp_fault) begin
                    errors++;
                    $display("FAIL rnd_deliver cyc=%0d pcF=%h snpcF=%h instF=%h fault=%b required %h %h %h %b", cyc, pcF, snpcF, instF,
                             fetch_fault, exp_pc, exp_pc + 32'd4, mem_word(exp_pc), exp_fault);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end
            if (pend) begin
                if (bus.rvalid && bus.rready === 1'b1) begin
                    pend = 1'b0;
                end else if (cnt > 0) begin
                    cnt--;
                end
            end else if (bus.arvalid === 1'b1 && bus.arready) begin
                pend      = 1'b1;
                pend_addr = bus.araddr;
                cnt       = $urandom_range(0, 2);
            end
            prev_stall = (bus.arvalid === 1'b1) && !bus.arready;
            prev_addr  = bus.araddr;
            prev_hold  = (m_valid === 1'b1) && !m_ready;
            prev_pcf   = pcF;
            prev_inst  = instF;
            @(negedge clk);
        end
        checks++;
        if (delivered < 50) begin
            errors++;
            $display("FAIL rnd_progress delivered=%0d required at least 50", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ar_stall();
        test_r_delay();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_fault();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
